// File: rtl/hdmi_audio_scheduler_if.sv
// Stereo PCM handshake between the sound core (producer) and the HDMI audio scheduler.
interface hdmi_audio_scheduler_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_left;
    logic [W-1:0] in_right;

    modport master (output in_valid, in_left, in_right, input in_ready);
    modport slave  (input in_valid, in_left, in_right, output in_ready);
endinterface

// File: rtl/hdmi_audio_scheduler.sv
// Buffers stereo PCM, derives clk_audio from clk with a fractional accumulator and
// presents sample words to the HDMI block with priming, underflow recovery and muting.
module hdmi_audio_scheduler #(
    parameter int CLK_HZ          = 27000000,
    parameter int AUDIO_RATE      = 44100,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    hdmi_audio_scheduler_if.slave            aud,
    output logic                             clk_audio,
    output logic [AUDIO_BIT_WIDTH-1:0]       audio_sample_word [2],
    output logic                             include_audio,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic [7:0]                       underflow_count
);
    localparam int ACC_W = $clog2(CLK_HZ) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ACC_W-1:0] ACC_STEP  = ACC_W'(2 * AUDIO_RATE);
    localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(CLK_HZ);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_HALF  = LVL_W'(FIFO_DEPTH / 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [ACC_W-1:0]           acc;
    logic [ACC_W-1:0]           acc_n;
    logic                       tick;
    logic                       fall_tick;
    logic [1:0]                 state;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [AUDIO_BIT_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [AUDIO_BIT_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AUDIO_BIT_WIDTH-1:0] word_l;
    logic [AUDIO_BIT_WIDTH-1:0] word_r;
    logic                       push;
    logic                       pop;

    // acc_n cannot overflow: acc < CLK_HZ and 2*AUDIO_RATE < CLK_HZ
    assign acc_n     = acc + ACC_STEP;
    assign tick      = (acc_n >= ACC_LIMIT);
    assign fall_tick = tick & clk_audio;

    assign aud.in_ready = (state != ST_IDLE) && (fifo_level != LVL_FULL);
    assign push = aud.in_valid & aud.in_ready;
    assign pop  = enable && (state == ST_RUN) && fall_tick && (fifo_level != '0);

    assign audio_sample_word[0] = word_l;
    assign audio_sample_word[1] = word_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            clk_audio <= 1'b0;
        end else begin
            acc <= tick ? (acc_n - ACC_LIMIT) : acc_n;
            if (tick) clk_audio <= ~clk_audio;
        end
    end

    // Sample storage carries no reset; pointers and level define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= aud.in_left;
            mem_r[wr_ptr] <= aud.in_right;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_level      <= '0;
            include_audio   <= 1'b0;
            word_l          <= '0;
            word_r          <= '0;
            underflow_count <= '0;
        end else if (!enable) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            include_audio <= 1'b0;
            word_l        <= '0;
            word_r        <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
            case (state)
                ST_IDLE: begin
                    state         <= ST_PRIME;
                    include_audio <= 1'b1;
                end
                ST_PRIME: begin
                    if (fall_tick) begin
                        word_l <= '0;
                        word_r <= '0;
                    end
                    if (fifo_level >= LVL_HALF) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (fall_tick) begin
                        if (fifo_level != '0) begin
                            word_l <= mem_l[rd_ptr];
                            word_r <= mem_r[rd_ptr];
                        end else begin
                            word_l <= '0;
                            word_r <= '0;
                            state  <= ST_PRIME;
                            if (underflow_count != 8'hFF) underflow_count <= underflow_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    include_audio <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hdmi_audio_scheduler.sv
// Randomized scoreboard bench for hdmi_audio_scheduler against a queue-based reference model.
module tb_hdmi_audio_scheduler;
    localparam int CLK_HZ = 1000;
    localparam int RATE   = 100;
    localparam int W      = 16;
    localparam int DEPTH  = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         clk_audio;
    logic [W-1:0] audio_sample_word [2];
    logic         include_audio;
    logic [3:0]   fifo_level;
    logic [7:0]   underflow_count;

    hdmi_audio_scheduler_if #(.W(W)) bif ();

    hdmi_audio_scheduler #(
        .CLK_HZ(CLK_HZ), .AUDIO_RATE(RATE), .AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .aud(bif.slave),
        .clk_audio(clk_audio), .audio_sample_word(audio_sample_word),
        .include_audio(include_audio), .fifo_level(fifo_level),
        .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ck;
        logic         inc;
        logic         rdy;
        logic [3:0]   lvl;
        logic [7:0]   uc;
        logic [W-1:0] wl;
        logic [W-1:0] wr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: sample-clock ticks from elapsed cycles, FIFO as a queue
    longint       m_n = 0;
    logic         m_ck = 1'b0;
    int           m_mode = 0;           // 0 muted, 1 priming, 2 streaming
    logic [31:0]  m_q[$];
    logic [W-1:0] m_wl = '0, m_wr = '0;
    logic         m_inc = 1'b0;
    int           m_uc = 0;
    logic         last_push = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic en, input logic v, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic rst);
        exp_t e;
        bit   tick, fall, rdy;
        int   sz;
        @(negedge clk);
        reset_n      = !rst;
        enable       = en;
        bif.in_valid = v;
        bif.in_left  = l;
        bif.in_right = r;
        last_push    = 1'b0;
        if (rst) begin
            m_n = 0; m_ck = 0; m_mode = 0; m_q.delete();
            m_wl = '0; m_wr = '0; m_inc = 0; m_uc = 0;
        end else begin
            m_n++;
            tick = ((m_n * 2 * RATE) / CLK_HZ) != (((m_n - 1) * 2 * RATE) / CLK_HZ);
            fall = tick && m_ck;
            sz   = m_q.size();
            rdy  = (m_mode != 0) && (sz != DEPTH);
            if (!en) begin
                m_mode = 0; m_q.delete(); m_wl = '0; m_wr = '0; m_inc = 0;
            end else begin
                if (m_mode == 0) begin
                    m_mode = 1; m_inc = 1;
                end else if (m_mode == 1) begin
                    if (fall) begin m_wl = '0; m_wr = '0; end
                    if (sz >= DEPTH / 2) m_mode = 2;
                end else if (fall) begin
                    if (sz > 0) begin
                        {m_wl, m_wr} = m_q.pop_front();
                    end else begin
                        m_wl = '0; m_wr = '0; m_mode = 1;
                        if (m_uc < 255) m_uc++;
                    end
                end
                if (v && rdy) begin
                    m_q.push_back({l, r});
                    last_push = 1'b1;
                end
            end
            if (tick) m_ck = !m_ck;
        end
        e.ck  = m_ck;
        e.inc = m_inc;
        e.rdy = (m_mode != 0) && (m_q.size() != DEPTH);
        e.lvl = 4'(m_q.size());
        e.uc  = 8'(m_uc);
        e.wl  = m_wl;
        e.wr  = m_wr;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("clk_audio", 32'(clk_audio), 32'(e.ck));
            check("include_audio", 32'(include_audio), 32'(e.inc));
            check("in_ready", 32'(bif.in_ready), 32'(e.rdy));
            check("fifo_level", 32'(fifo_level), 32'(e.lvl));
            check("underflow_count", 32'(underflow_count), 32'(e.uc));
            check("word_left", 32'(audio_sample_word[0]), 32'(e.wl));
            check("word_right", 32'(audio_sample_word[1]), 32'(e.wr));
        end
    end

    task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        int n = 0;
        do begin
            step(1'b1, 1'b1, l, r, 1'b0);
            n++;
        end while (!last_push && n < 100);
        if (!last_push) check("push_accept_timeout", 32'(0), 32'(1));
    endtask

    // Producer holds an unaccepted sample until it is taken
    logic         p_pend = 1'b0;
    logic         p_v;
    logic [W-1:0] p_l, p_r;
    task automatic random_stream(input int cycles, input int valid_pct);
        for (int i = 0; i < cycles; i++) begin
            if (!p_pend) begin
                p_v = ($urandom_range(99) < valid_pct);
                p_l = W'($urandom);
                p_r = W'($urandom);
            end
            step(1'b1, p_v, p_l, p_r, 1'b0);
            p_pend = p_v && !last_push;
        end
    endtask

    initial begin
        int prev_uc, n;
        bif.in_valid = 1'b0;
        bif.in_left  = '0;
        bif.in_right = '0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++)
            step(1'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'b1);
        check("reset_level", 32'(fifo_level), 32'(0));
        check("reset_ready", 32'(bif.in_ready), 32'(0));

        // Muted: sample clock runs, no audio
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'($urandom), W'($urandom), W'($urandom), 1'b0);

        // Prime with four pairs, stream them, then underflow
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int k = 1; k <= 4; k++) push_pair(W'(16'h1111 * k), W'(16'h2222 * k));
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
        check("uc_after_underflow", 32'(underflow_count), 32'(1));
        check("include_after_underflow", 32'(include_audio), 32'(1));

        // Random streaming, then a saturating burst to fill the FIFO
        random_stream(300, 60);
        random_stream(60, 100);
        check("level_full", 32'(fifo_level), 32'(DEPTH));

        // Disable mid-stream
        step(1'b0, 1'b1, 16'h5a5a, 16'ha5a5, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("disable_include", 32'(include_audio), 32'(0));
        check("disable_level", 32'(fifo_level), 32'(0));
        p_pend = 1'b0;
        random_stream(150, 70);

        // Asynchronous reset mid-stream
        step(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b1);
        p_pend = 1'b0;
        random_stream(150, 50);

        // Force 300 underflows
        for (int u = 0; u < 300; u++) begin
            prev_uc = m_uc;
            for (int k = 0; k < 4; k++) push_pair(W'($urandom), W'($urandom));
            n = 0;
            while (m_uc == prev_uc && m_uc < 255 && n < 300) begin
                step(1'b1, 1'b0, '0, '0, 1'b0);
                n++;
            end
            if (n >= 300) check("underflow_timeout", 32'(0), 32'(1));
            if (m_uc == 255 && prev_uc == 255) begin
                for (int i = 0; i < 60; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
            end
        end
        check("uc_saturated", 32'(underflow_count), 32'(255));

        step(1'b1, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
